fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 53 +++++
 rtl/fifo_wr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write-side arbiter:
//   - default parameter values (data width, requester count, burst length)
//   - FSM state encoding (IDLE = 0, BURST = 1)
//   - helper to size the beat counter
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    localparam int DATA_SIZE_DEF = 4;
    localparam int NUM_REQ_DEF   = 4;
    localparam int MAX_BURST_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Beat counter only has to reach MAX_BURST-1; keep at least one bit so a
    // single-beat configuration still has a legal vector.
    function automatic int cnt_width(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches the request vector starting at
// (last_owner + 1) mod NUM_REQ, wrapping upward, and reports the first hit.
// Ports:
//   req        in  [NUM_REQ-1:0]  request vector
//   last_owner in  [IDX_W-1:0]    index of the previous burst owner
//   valid      out                at least one request is set
//   index      out [IDX_W-1:0]    index of the chosen requester (0 if none)
// -----------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    // Candidate gi is the requester examined at search offset gi, i.e.
    // (last_owner + 1 + gi) mod NUM_REQ. One extra bit holds the unwrapped sum;
    // since NUM_REQ <= 2**IDX_W the sum never exceeds 2*NUM_REQ-1.
    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, last_owner} + (IDX_W+1)'(gi + 1);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ))
                                ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                : IDX_W'(sum);
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                valid = 1'b1;
                index = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin burst arbiter in front of a FIFO write port. In IDLE it picks the
// next requester (one cycle of arbitration), then in BURST it streams that
// requester's beats straight to the FIFO until the requester marks its last
// beat, MAX_BURST beats have been written, or the requester drops its request.
// A full FIFO stalls the burst indefinitely.
//
// Optional build macro: FIFO_ARB_STATS_EN adds a 16-bit saturating stall_cnt
// output counting BURST cycles where the owner requests but the FIFO is full.
//
// Ports:
//   wr_clk    in                        clock (rising edge)
//   wr_rst    in                        synchronous active-high reset
//   req       in  [NUM_REQ-1:0]         per-requester write request (level)
//   req_last  in  [NUM_REQ-1:0]         final beat of requester's burst
//   req_data  in  [NUM_REQ*DATA_SIZE-1:0] requester i data at [i*DATA_SIZE +: DATA_SIZE]
//   ack       out [NUM_REQ-1:0]         one-hot beat accepted
//   full      in                        FIFO full
//   wr_en     out                       FIFO write enable
//   wr_data   out [DATA_SIZE-1:0]       FIFO write data
//   grant_id  out [IDX_W-1:0]           burst owner, 0 when idle
//   busy      out                       high in BURST
//   stall_cnt out [15:0]                (FIFO_ARB_STATS_EN only) stall cycles
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int DATA_SIZE = DATA_SIZE_DEF,
    parameter  int NUM_REQ   = NUM_REQ_DEF,
    parameter  int MAX_BURST = MAX_BURST_DEF,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                           wr_clk,
    input  logic                           wr_rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_last,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             ack,
    input  logic                           full,
    output logic                           wr_en,
    output logic [DATA_SIZE-1:0]           wr_data,
    output logic [IDX_W-1:0]               grant_id,
`ifdef FIFO_ARB_STATS_EN
    output logic [15:0]                    stall_cnt,
`endif
    output logic                           busy
);

    localparam int               CNT_W     = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t       state_reg, state_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [IDX_W-1:0] last_owner_reg, last_owner_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_index;
    logic             owner_req;
    logic             owner_last;
    logic             accept;

    logic [DATA_SIZE-1:0] data_slice [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign data_slice[gi] = req_data[gi*DATA_SIZE +: DATA_SIZE];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner_reg),
        .valid      (pick_valid),
        .index      (pick_index)
    );

    assign owner_req  = req[owner_reg];
    assign owner_last = req_last[owner_reg];
    assign accept     = (state_reg == BURST) && owner_req && !full;

    // ------------------------------------------------------------------ state
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_owner_reg <= IDX_W'(NUM_REQ - 1);
            beat_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            beat_cnt_reg   <= beat_cnt_next;
        end
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        beat_cnt_next   = beat_cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next    = BURST;
                    owner_next    = pick_index;
                    beat_cnt_next = '0;
                end
            end
            BURST: begin
                if (!owner_req) begin
                    // Requester walked away mid-burst: give the slot up.
                    state_next      = IDLE;
                    last_owner_next = owner_reg;
                end else if (accept) begin
                    beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    if (owner_last || (beat_cnt_reg == LAST_BEAT)) begin
                        state_next      = IDLE;
                        last_owner_next = owner_reg;
                    end
                end
                // owner requesting but FIFO full: everything holds
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Outputs are forced to their idle values while wr_rst is high so the FIFO
    // never sees a write in the cycle the reset is being applied.
    always_comb begin
        ack      = '0;
        wr_en    = 1'b0;
        grant_id = '0;
        busy     = 1'b0;
        if ((state_reg == BURST) && !wr_rst) begin
            busy           = 1'b1;
            grant_id       = owner_reg;
            wr_en          = accept;
            ack[owner_reg] = accept;
        end
    end

    assign wr_data = data_slice[owner_reg];

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == BURST) && owner_req && full
                     && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed scenarios drive a small requester model; expected FIFO beats are
// pushed into a queue when each scenario is set up, and a negedge monitor pops
// and compares every beat the arbiter writes. Directed state checks cover
// arbitration latency, idle gaps, stalls, abandonment and reset.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int DW = 4;
    localparam int NR = 4;
    localparam int MB = 8;

    logic            wr_clk = 1'b0;
    logic            wr_rst = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]   ack;
    logic            full = 1'b0;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0]     stall_cnt;
`endif

    fifo_wr_arbiter #(
        .DATA_SIZE (DW),
        .NUM_REQ   (NR),
        .MAX_BURST (MB)
    ) dut (
        .wr_clk    (wr_clk),
        .wr_rst    (wr_rst),
        .req       (req),
        .req_last  (req_last),
        .req_data  (req_data),
        .ack       (ack),
        .full      (full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
`ifdef FIFO_ARB_STATS_EN
        .stall_cnt (stall_cnt),
`endif
        .busy      (busy)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // requester model state
    int   rem [NR];
    int   beat [NR];
    int   bb [NR];
    int   last_every [NR];
    logic [NR-1:0] ack_s;
    logic rst_v = 1'b1;

    function automatic logic [3:0] data_of(input int i, input int b);
        logic [1:0] ii;
        logic [1:0] bl;
        ii = i[1:0];
        bl = b[1:0];
        return {ii, bl} ^ 4'h5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req[i]      = (rem[i] > 0);
            req_last[i] = (last_every[i] != 0) && (bb[i] == last_every[i] - 1);
            req_data[i*DW +: DW] = data_of(i, beat[i]);
        end
        wr_rst = rst_v;
    endtask

    // One clock: capture acks before the edge, advance requesters after it.
    task automatic step();
        @(negedge wr_clk);
        ack_s = ack;
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (ack_s[i]) begin
                beat[i]++;
                rem[i]--;
                if (req_last[i]) bb[i] = 0;
                else             bb[i]++;
            end
        end
        drive();
        #1;
    endtask

    task automatic expect_beats(input int id, input int first, input int n);
        logic [1:0] ii;
        ii = id[1:0];
        for (int k = 0; k < n; k++)
            exp_q.push_back(exp_t'{id: ii, data: data_of(id, first + k)});
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0; beat[i] = 0; bb[i] = 0; last_every[i] = 0;
        end
    endtask

    task automatic do_reset();
        rst_v = 1'b1;
        full  = 1'b0;
        clear_model();
        drive();
        step();
        step();
        chk("rst ack", ack, 0);
        chk("rst wr_en", wr_en, 0);
        chk("rst busy", busy, 0);
        chk("rst grant_id", grant_id, 0);
        chk("rst wr_data", wr_data, data_of(0, 0));
        rst_v = 1'b0;
        drive();
        #1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((rem[0] > 0 || rem[1] > 0 || rem[2] > 0 || rem[3] > 0 || busy) && n < 300) begin
            step();
            n++;
        end
        chk({name, " completes in budget"}, (n < 300), 1);
        chk({name, " queue drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every FIFO write must match the head of the expected queue.
    always @(negedge wr_clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                chk("spurious beat (queue depth)", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("beat grant_id", grant_id, e.id);
                chk("beat wr_data", wr_data, e.data);
                chk("beat ack", ack, 4'b0001 << e.id);
            end
        end else if (!wr_rst) begin
            chk("no-write ack", ack, 0);
        end
    end

    initial begin
        clear_model();
        drive();

        // T1: req 0101, no last -> 8 beats to 0, one idle cycle, then 2.
        do_reset();
        rem[0] = 8; rem[2] = 8;
        expect_beats(0, 0, 8);
        expect_beats(2, 0, 8);
        drive(); #1;
        chk("t1 idle before arb", busy, 0);
        step();
        chk("t1 first grant", grant_id, 0);
        chk("t1 busy", busy, 1);
        repeat (8) step();
        chk("t1 gap busy", busy, 0);
        chk("t1 gap wr_en", wr_en, 0);
        step();
        chk("t1 second grant", grant_id, 2);
        wait_done("t1");

        // T2: all requesting, last on every 3rd beat -> 0,1,2,3,0.
        do_reset();
        rem[0] = 6; rem[1] = 3; rem[2] = 3; rem[3] = 3;
        for (int i = 0; i < NR; i++) last_every[i] = 3;
        expect_beats(0, 0, 3);
        expect_beats(1, 0, 3);
        expect_beats(2, 0, 3);
        expect_beats(3, 0, 3);
        expect_beats(0, 3, 3);
        drive(); #1;
        step();
        chk("t2 first grant", grant_id, 0);
        wait_done("t2");

        // T3: owner 1 stalls for 5 cycles after 2 beats; 10 beats total
        // means one full 8-beat burst then a re-grant for 2 more.
        do_reset();
        rem[1] = 10;
        expect_beats(1, 0, 10);
        drive(); #1;
        step();
        chk("t3 grant", grant_id, 1);
        step();
        step();
        full = 1'b1; #1;
        chk("t3 stall wr_en", wr_en, 0);
        chk("t3 stall ack", ack, 0);
        repeat (5) step();
        chk("t3 stall holds burst", busy, 1);
`ifdef FIFO_ARB_STATS_EN
        chk("t3 stall_cnt", stall_cnt, 5);
`endif
        full = 1'b0; #1;
        repeat (5) step();
        chk("t3 burst not ended early", busy, 1);
        step();
        chk("t3 burst ends at 8 beats", busy, 0);
        wait_done("t3");

        // T4: owner 2 drops after 2 beats -> idle next, then search from 3.
        do_reset();
        rem[2] = 2;
        expect_beats(2, 0, 2);
        expect_beats(3, 0, 1);
        expect_beats(0, 0, 1);
        drive(); #1;
        step();
        chk("t4 grant", grant_id, 2);
        rem[0] = 1; rem[3] = 1;
        drive(); #1;
        step();
        step();
        chk("t4 dropped wr_en", wr_en, 0);
        chk("t4 dropped still busy", busy, 1);
        step();
        chk("t4 abandoned idle", busy, 0);
        step();
        chk("t4 next grant", grant_id, 3);
        wait_done("t4");

        // T5: reset while beat 4 of requester 0 is presented.
        do_reset();
        rem[0] = 10;
        expect_beats(0, 0, 4);
        drive(); #1;
        repeat (5) step();
        rst_v = 1'b1;
        drive(); #1;
        step();
        chk("t5 post-rst busy", busy, 0);
        chk("t5 post-rst wr_en", wr_en, 0);
        rst_v = 1'b0;
        rem[1] = 1; rem[2] = 1; rem[3] = 1;
        expect_beats(0, 4, 6);
        expect_beats(1, 0, 1);
        expect_beats(2, 0, 1);
        expect_beats(3, 0, 1);
        drive(); #1;
        step();
        chk("t5 first grant after rst", grant_id, 0);
        wait_done("t5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
